// File: rtl/morphologic_frame_uart_tx.sv
// Packs the binary pixel stream of the morphologic operator into bytes
// (first pixel of a byte in bit 7), prefixes every frame with a sync byte,
// queues the bytes in a small FIFO and shifts them out as 8N1 UART on tx.
module morphologic_frame_uart_tx #(
  parameter int         WIDTH        = 32,
  parameter int         HEIGHT       = 24,
  parameter int         CLKS_PER_BIT = 4,
  parameter int         FIFO_DEPTH   = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic pixel_in,
  input  logic pixel_valid,
  input  logic frame_start,
  output logic pixel_ready,
  output logic tx,
  output logic busy
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CLK_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [AW:0]      OCC_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]      READY_MAX = (AW + 1)'(FIFO_DEPTH - 2);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
  localparam logic [CLK_W-1:0] BIT_LAST  = CLK_W'(CLKS_PER_BIT - 1);

  typedef enum logic {P_IDLE, P_PACK} p_state_t;
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} u_state_t;

  p_state_t         p_state, p_nxt;
  u_state_t         u_state, u_nxt;

  logic             accept;
  logic             last_pix;
  logic [CNT_W-1:0] pix_cnt, pix_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       sh_byte, sh_byte_nxt;
  logic [7:0]       merged;
  logic             push;
  logic [7:0]       push_data;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             pop;

  logic [CLK_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic             bit_done;
  logic [7:0]       tx_byte;
  logic             tx_nxt;

  assign accept   = pixel_valid && pixel_ready;
  assign last_pix = (pix_cnt == LAST_CNT);
  assign pop      = (u_state == U_IDLE) && (count != '0);
  assign bit_done = (clk_cnt == BIT_LAST);
  assign busy     = (p_state != P_IDLE) || (count != '0) || (u_state != U_IDLE);

  // Packer state register and its frame/byte counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_state <= P_IDLE;
      pix_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      p_state <= p_nxt;
      pix_cnt <= pix_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Partial byte being assembled; pure data, so it carries no reset.
  always_ff @(posedge clk) begin
    sh_byte <= sh_byte_nxt;
  end

  // Packer next state: a frame_start always (re)opens a frame, the last pixel closes it.
  always_comb begin
    p_nxt = p_state;
    if (accept) begin
      if (frame_start) begin
        p_nxt = P_PACK;
      end else if ((p_state == P_PACK) && last_pix) begin
        p_nxt = P_IDLE;
      end
    end
  end

  // Packer outputs: header push on frame_start, data push on a full or final byte.
  always_comb begin
    push        = 1'b0;
    push_data   = sh_byte;
    sh_byte_nxt = sh_byte;
    pix_cnt_nxt = pix_cnt;
    bit_cnt_nxt = bit_cnt;
    // A fresh byte starts from zero, which also pads a short final byte.
    merged      = (bit_cnt == 3'd0) ? 8'h00 : sh_byte;
    merged[3'd7 - bit_cnt] = pixel_in;
    if (accept) begin
      if (frame_start) begin
        // Any partial byte of an interrupted frame is dropped here.
        push        = 1'b1;
        push_data   = SYNC_BYTE;
        sh_byte_nxt = {pixel_in, 7'b0};
        pix_cnt_nxt = CNT_ONE;
        bit_cnt_nxt = 3'd1;
      end else if (p_state == P_PACK) begin
        sh_byte_nxt = merged;
        pix_cnt_nxt = pix_cnt + CNT_ONE;
        bit_cnt_nxt = bit_cnt + 3'd1;
        if ((bit_cnt == 3'd7) || last_pix) begin
          push      = 1'b1;
          push_data = merged;
        end
        if (last_pix) begin
          pix_cnt_nxt = '0;
          bit_cnt_nxt = 3'd0;
        end
      end
    end
  end

  // FIFO occupancy after this edge's push and pop.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + OCC_ONE;
      2'b01:   count_nxt = count - OCC_ONE;
      default: count_nxt = count;
    endcase
  end

  // FIFO pointers, occupancy and registered ready (at least two free slots).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pixel_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count       <= count_nxt;
      pixel_ready <= (count_nxt <= READY_MAX);
    end
  end

  // FIFO storage and the UART byte register loaded on pop.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
    if (pop)  tx_byte     <= mem[rd_ptr];
  end

  // UART state register with bit-period and bit-index counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      u_state <= U_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
    end else begin
      u_state <= u_nxt;
      if ((u_state == U_IDLE) || bit_done) begin
        clk_cnt <= '0;
      end else begin
        clk_cnt <= clk_cnt + CLK_W'(1);
      end
      if (u_state == U_IDLE) begin
        bit_idx <= '0;
      end else if ((u_state == U_DATA) && bit_done) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // UART next state: start, eight data bits, stop, then one idle cycle to pop.
  always_comb begin
    u_nxt = u_state;
    case (u_state)
      U_IDLE:  if (count != '0) u_nxt = U_START;
      U_START: if (bit_done) u_nxt = U_DATA;
      U_DATA:  if (bit_done && (bit_idx == 3'd7)) u_nxt = U_STOP;
      U_STOP:  if (bit_done) u_nxt = U_IDLE;
      default: u_nxt = U_IDLE;
    endcase
  end

  // UART line level for the current state, LSB first.
  always_comb begin
    tx_nxt = 1'b1;
    case (u_state)
      U_START: tx_nxt = 1'b0;
      U_DATA:  tx_nxt = tx_byte[bit_idx];
      default: tx_nxt = 1'b1;
    endcase
  end

  // Registered line driver; reset forces the line idle immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx <= 1'b1;
    end else begin
      tx <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_morphologic_frame_uart_tx.sv
// Bench for morphologic_frame_uart_tx: three instances (4x4, 3x3, 32x24 with a
// 4-deep FIFO) share clock and reset; one UART decoder follows the selected tx.
module tb_morphologic_frame_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       pixel_in, pixel_valid, frame_start;
  logic [1:0] sel;
  logic       va, vb, vc;
  logic       rdy_a, rdy_b, rdy_c, tx_a, tx_b, tx_c, busy_a, busy_b, busy_c;
  logic       rdy_sel, tx_mon, busy_sel;

  assign va = pixel_valid && (sel == 2'd0);
  assign vb = pixel_valid && (sel == 2'd1);
  assign vc = pixel_valid && (sel == 2'd2);
  assign rdy_sel  = (sel == 2'd0) ? rdy_a  : (sel == 2'd1) ? rdy_b  : rdy_c;
  assign tx_mon   = (sel == 2'd0) ? tx_a   : (sel == 2'd1) ? tx_b   : tx_c;
  assign busy_sel = (sel == 2'd0) ? busy_a : (sel == 2'd1) ? busy_b : busy_c;

  morphologic_frame_uart_tx #(.WIDTH(4), .HEIGHT(4), .CLKS_PER_BIT(4), .FIFO_DEPTH(16), .SYNC_BYTE(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(va), .frame_start(frame_start),
    .pixel_ready(rdy_a), .tx(tx_a), .busy(busy_a));
  morphologic_frame_uart_tx #(.WIDTH(3), .HEIGHT(3), .CLKS_PER_BIT(4), .FIFO_DEPTH(16), .SYNC_BYTE(8'hA5)) dut_b (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(vb), .frame_start(frame_start),
    .pixel_ready(rdy_b), .tx(tx_b), .busy(busy_b));
  morphologic_frame_uart_tx #(.WIDTH(32), .HEIGHT(24), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .SYNC_BYTE(8'hA5)) dut_c (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(vc), .frame_start(frame_start),
    .pixel_ready(rdy_c), .tx(tx_c), .busy(busy_c));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  int         rx_cnt = 0;
  logic       abort_flag = 1'b0;
  logic       saw_stall = 1'b0;
  int         acc_cyc = 0;

  typedef struct {
    logic [1:0] dut;
    logic       pix;
    logic       fs;
    logic       exp_vld;
    logic [7:0] exp_byte;
    logic       drain;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] d, input logic p, input logic f,
                     input logic ev, input logic [7:0] eb, input logic dr);
    vec_t v;
    v.dut = d; v.pix = p; v.fs = f; v.exp_vld = ev; v.exp_byte = eb; v.drain = dr;
    vecs.push_back(v);
  endtask

  task automatic send_pix(input logic p, input logic fs);
    int w;
    @(negedge clk);
    pixel_in = p; frame_start = fs; pixel_valid = 1'b1; w = 0;
    while (!rdy_sel && w < 500) begin
      saw_stall = 1'b1;
      @(negedge clk);
      w++;
    end
    if (w >= 500) begin
      checks++; errors++;
      $display("FAIL pixel_ready_timeout actual=0 expected=1");
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic drain(input string nm);
    int w;
    @(negedge clk);
    pixel_valid = 1'b0; frame_start = 1'b0; w = 0;
    while ((busy_sel || exp_q.size() != 0) && w < 6000) begin
      @(negedge clk);
      w++;
    end
    repeat (5) @(negedge clk);
    check({nm, "_pending_bytes"}, exp_q.size(), 0);
    check({nm, "_idle_tx_busy"}, {tx_mon, busy_sel}, 2'b10);
  endtask

  // UART decoder: samples mid-bit on falling edges, compares against the scoreboard.
  always begin : mon
    logic [7:0] b;
    logic [7:0] e;
    logic       sbit, pbit;
    @(negedge clk);
    if (tx_mon === 1'b0 && !rst) begin
      starts.push_back(cyc);
      repeat (2) @(negedge clk);
      sbit = tx_mon;
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        b[i] = tx_mon;
      end
      repeat (4) @(negedge clk);
      pbit = tx_mon;
      if (!abort_flag) begin
        rx_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected actual=%02h expected=none", b);
        end else begin
          e = exp_q.pop_front();
          if ({sbit, b, pbit} !== {1'b0, e, 1'b1}) begin
            errors++;
            $display("FAIL rx_byte actual=%02h(start=%0b stop=%0b) expected=%02h", b, sbit, pbit, e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [15:0] pat;
    logic        img [768];
    logic [7:0]  acc;
    int          fs_cyc, rx0, w;

    rst = 1'b1; pixel_in = 1'b0; pixel_valid = 1'b0; frame_start = 1'b0; sel = 2'd0;

    // 4x4 frame: A5, B1, 55
    pat = 16'b1011_0001_0101_0101;
    for (int i = 0; i < 16; i++)
      add(2'd0, pat[15-i], i == 0, (i == 0) || (i == 7) || (i == 15),
          (i == 0) ? 8'hA5 : (i == 7) ? 8'hB1 : 8'h55, i == 15);
    // 3x3 all-ones frame: A5, FF, 80; then 8 stray pixels that must be dropped
    for (int i = 0; i < 9; i++)
      add(2'd1, 1'b1, i == 0, (i == 0) || (i == 7) || (i == 8),
          (i == 0) ? 8'hA5 : (i == 7) ? 8'hFF : 8'h80, 1'b0);
    for (int i = 0; i < 8; i++) add(2'd1, 1'b1, 1'b0, 1'b0, 8'h00, i == 7);
    // restart after 5 pixels: A5, A5, F0, 0F
    for (int i = 0; i < 5; i++) add(2'd0, 1'b1, i == 0, i == 0, 8'hA5, 1'b0);
    pat = 16'b1111_0000_0000_1111;
    for (int i = 0; i < 16; i++)
      add(2'd0, pat[15-i], i == 0, (i == 0) || (i == 7) || (i == 15),
          (i == 0) ? 8'hA5 : (i == 7) ? 8'hF0 : 8'h0F, i == 15);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_idle_a", {tx_a, rdy_a, busy_a}, 3'b110);
    end
    check("reset_idle_b", {tx_b, rdy_b, busy_b}, 3'b110);
    check("reset_idle_c", {tx_c, rdy_c, busy_c}, 3'b110);

    // Table-driven frames
    fs_cyc = 0;
    for (int k = 0; k < vecs.size(); k++) begin
      sel = vecs[k].dut;
      if (vecs[k].exp_vld) exp_q.push_back(vecs[k].exp_byte);
      send_pix(vecs[k].pix, vecs[k].fs);
      if (k == 0) fs_cyc = acc_cyc;
      if (vecs[k].drain) drain("table");
    end
    check("rx_count_table", rx_cnt, 10);
    check("start_latency", (starts.size() > 0) ? starts[0] - fs_cyc : -1, 2);
    check("byte_spacing_1", (starts.size() > 2) ? starts[1] - starts[0] : -1, 41);
    check("byte_spacing_2", (starts.size() > 2) ? starts[2] - starts[1] : -1, 41);

    // Pixels without frame_start while idle are dropped
    sel = 2'd0;
    rx0 = rx_cnt;
    for (int i = 0; i < 5; i++) begin
      send_pix(1'b1, 1'b0);
      check("nofs_busy", busy_a, 1'b0);
    end
    @(negedge clk);
    pixel_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("nofs_line_idle", {tx_a, busy_a}, 2'b10);
    end
    check("nofs_rx_count", rx_cnt - rx0, 0);

    // Full 32x24 frame through a 4-deep FIFO with backpressure
    sel = 2'd2;
    rx0 = rx_cnt;
    saw_stall = 1'b0;
    for (int i = 0; i < 768; i++) img[i] = 1'($urandom_range(0, 1));
    exp_q.push_back(8'hA5);
    acc = 8'h00;
    for (int i = 0; i < 768; i++) begin
      acc = {acc[6:0], img[i]};
      if ((i % 8) == 7) exp_q.push_back(acc);
      send_pix(img[i], i == 0);
    end
    drain("big_frame");
    check("big_rx_count", rx_cnt - rx0, 97);
    check("big_backpressure", saw_stall, 1'b1);

    // Reset in the middle of a transmission
    send_pix(1'b1, 1'b1);
    for (int i = 0; i < 15; i++) send_pix(1'b0, 1'b0);
    @(negedge clk);
    pixel_valid = 1'b0; frame_start = 1'b0; w = 0;
    while (tx_c !== 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("abort_tx_low_before_reset", tx_c, 1'b0);
    abort_flag = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_after_reset", {tx_c, rdy_c, busy_c}, 3'b110);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("abort_stays_idle", {tx_c, busy_c}, 2'b10);
    end
    exp_q.delete();
    abort_flag = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morphologic_frame_uart_tx.md
Name: morphologic_frame_uart_tx

Overview:
- Downstream stage of the debug morphologic processor.
- Accepts the binary pixel stream produced by the morphologic operator and packs 8 pixels per byte.
- Prefixes each frame with a sync byte, buffers bytes in a FIFO and shifts them out as 8N1 UART on a single `tx` line.
- Gives bench and board a frame-delimited serial dump of the processed image.

Parameters:
- WIDTH, 32, image width in pixels.
- HEIGHT, 24, image height in pixels.
- CLKS_PER_BIT, 4, clk cycles per UART bit (minimum 2).
- FIFO_DEPTH, 16, byte FIFO depth (power of two, minimum 4).
- SYNC_BYTE, 8'hA5, frame header byte.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pixel_in  input  1  binary pixel (1 = foreground).
- pixel_valid  input  1  pixel_in is valid this cycle.
- frame_start  input  1  qualifies pixel_in as the first pixel of a frame; only meaningful with pixel_valid.
- pixel_ready  output  1  block can accept a pixel this cycle.
- tx  output  1  UART serial out, 8N1, LSB first, idle high; registered.
- busy  output  1  a frame is being packed, the FIFO is non-empty, or the UART is not IDLE.

Behaviour:
Reset:
- tx=1, pixel_ready=1, busy=0.
- FIFO empty, packer in P_IDLE, UART in U_IDLE, all counters 0.
- Reset asserted mid-byte aborts the transmission: tx returns high the next cycle and the FIFO is flushed.

Handshake:
- A pixel is accepted when pixel_valid && pixel_ready at the rising edge.
- pixel_ready = (FIFO free slots >= 2), registered from the current occupancy.

Packer FSM (P_IDLE, P_PACK):
- P_IDLE: accepted pixels without frame_start are dropped. An accepted pixel with frame_start pushes SYNC_BYTE to the FIFO, loads the pixel as bit 7 of the shift byte, sets pix_cnt=1 and goes to P_PACK.
- P_PACK: each accepted pixel shifts in MSB-first, so the first pixel of a byte lands in bit 7.
- When 8 bits are collected, the byte is pushed the same edge the 8th pixel is accepted.
- pix_cnt counts up to WIDTH*HEIGHT. When the last pixel is accepted, the current byte is pushed with unfilled low bits zero-padded, and the FSM returns to P_IDLE.
- frame_start accepted in P_PACK: the partial byte is discarded without a push, SYNC_BYTE is pushed, and the count restarts at 1 with the new pixel.
- At most one FIFO push per cycle is guaranteed. The header push (pixel 0) and the data push (pixel 8k−1 or last) never coincide, except on a restart whose dropped partial byte is never pushed.

FIFO:
- Synchronous, FIFO_DEPTH entries, wrap-around pointers.
- Push while full cannot occur because pixel_ready guards it.
- Simultaneous push and pop on the same edge keeps occupancy unchanged.

UART FSM (U_IDLE, U_START, U_DATA, U_STOP):
- U_IDLE: if the FIFO is non-empty, pop into the tx byte register and go to U_START.
- U_START: tx=0 for CLKS_PER_BIT cycles.
- U_DATA: bits 0..7, each held CLKS_PER_BIT cycles.
- U_STOP: tx=1 for CLKS_PER_BIT cycles, then U_IDLE.
- Back-to-back bytes: the pop happens in the U_IDLE cycle after stop, so consecutive bytes have 1 extra idle cycle. The frame on the line is therefore 10*CLKS_PER_BIT+1 cycles per byte.

Latency:
- A frame_start pixel accepted at edge N places the header in the FIFO at N.
- The UART pops at N+1 and tx falls after edge N+2.

busy:
- busy = (packer != P_IDLE) || FIFO non-empty || (UART != U_IDLE).

Test Plan:
1. Reset, hold idle 20 cycles -> tx=1, pixel_ready=1, busy=0 throughout.
2. WIDTH=4, HEIGHT=4, CLKS_PER_BIT=4: feed frame_start plus pixels 1,0,1,1,0,0,0,1 then 0,1,0,1,0,1,0,1 -> tx decodes bytes A5, B1, 55 in order. Start bit falls 2 cycles after the frame_start edge, 41 cycles per byte, then busy=0.
3. WIDTH=3, HEIGHT=3 (9 pixels, all 1) -> bytes A5, FF, 80 (last byte zero-padded); packer returns to P_IDLE after pixel 9.
4. 5 pixels without frame_start in P_IDLE -> no FIFO push, tx stays high, busy=0.
5. frame_start re-asserted after 5 pixels of a frame -> partial byte dropped. Output is A5 (first), A5 (second), then the bytes of the new frame only.
6. FIFO_DEPTH=4, continuous pixel_valid for a full 32×24 frame -> pixel_ready drops when free slots fall below 2. No byte is lost or duplicated: 97 bytes total (A5 plus 96 data bytes) match the reference image. Assert rst mid-transmission -> tx=1 the next cycle, FIFO empty, busy=0.
